// File: rtl/i2c_sensor_master.sv
// Bit-level single-master I2C engine: one addressed write or read per request.
// Drives open-drain SCL/SDA enables with registered outputs and a quarter-bit timer.
module i2c_sensor_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic [6:0] sensorAddr_I2C,
  input  logic [7:0] writeVal_I2C,
  input  logic       mode_I2C,
  input  logic       start_I2C,
  output logic [7:0] readVal_I2C,
  output logic       dataRdy_I2C,
  output logic       ack_err,
  output logic       busy,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_i
);

  localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [QW-1:0] QMAX = QW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ACK_A, WDATA, ACK_D, RDATA, MACK, STOP, DONE
  } state_t;

  state_t        state, state_d;
  logic [QW-1:0] qcnt, qcnt_d;
  logic [1:0]    quarter, quarter_d;
  logic [2:0]    bitcnt, bitcnt_d;
  logic [7:0]    addr_byte, data_byte, rx_shift, tx_byte;
  logic          mode_q, sda_sample;
  logic          tick, bit_end, sample_pt, latch;
  logic          tx_bit, scl_d, sda_d;

  // {scl_oe, sda_oe} for a given state and quarter; SCL is pulled low in q0-q1 of every bit
  function automatic logic [1:0] line_drive(input state_t st, input logic [1:0] q,
                                            input logic bit_v);
    case (st)
      START:                     return {1'b0, q[1]};
      ADDR, WDATA:               return {~q[1], ~bit_v};
      ACK_A, ACK_D, RDATA, MACK: return {~q[1], 1'b0};
      STOP:                      return {q == 2'd0, ~q[1]};
      default:                   return 2'b00;
    endcase
  endfunction

  always_comb begin
    state_d   = state;
    qcnt_d    = qcnt;
    quarter_d = quarter;
    bitcnt_d  = bitcnt;
    latch     = 1'b0;
    tick      = (qcnt == QMAX);
    bit_end   = tick && (quarter == 2'd3);
    sample_pt = tick && (quarter == 2'd2) && (state != IDLE) && (state != DONE);

    case (state)
      IDLE: begin
        qcnt_d    = '0;
        quarter_d = 2'd0;
        bitcnt_d  = 3'd0;
        if (start_I2C) begin
          latch   = 1'b1;
          state_d = START;
        end
      end
      DONE: begin
        qcnt_d    = '0;
        quarter_d = 2'd0;
        bitcnt_d  = 3'd0;
        state_d   = IDLE;
      end
      default: begin
        qcnt_d = tick ? '0 : qcnt + QW'(1);
        if (tick) quarter_d = quarter + 2'd1;
        if (bit_end) begin
          case (state)
            START: begin
              state_d  = ADDR;
              bitcnt_d = 3'd0;
            end
            ADDR: begin
              if (bitcnt == 3'd7) state_d = ACK_A;
              else                bitcnt_d = bitcnt + 3'd1;
            end
            ACK_A: begin
              bitcnt_d = 3'd0;
              if (sda_sample)  state_d = STOP;
              else if (mode_q) state_d = RDATA;
              else             state_d = WDATA;
            end
            WDATA: begin
              if (bitcnt == 3'd7) state_d = ACK_D;
              else                bitcnt_d = bitcnt + 3'd1;
            end
            RDATA: begin
              if (bitcnt == 3'd7) state_d = MACK;
              else                bitcnt_d = bitcnt + 3'd1;
            end
            ACK_D:   state_d = STOP;
            MACK:    state_d = STOP;
            STOP:    state_d = DONE;
            default: state_d = IDLE;
          endcase
        end
      end
    endcase

    // Pad drive is computed from the next state so the outputs can be registered glitch-free
    tx_byte        = (state_d == WDATA) ? data_byte : addr_byte;
    tx_bit         = tx_byte[3'd7 - bitcnt_d];
    {scl_d, sda_d} = line_drive(state_d, quarter_d, tx_bit);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      qcnt        <= '0;
      quarter     <= 2'd0;
      bitcnt      <= 3'd0;
      addr_byte   <= 8'h00;
      data_byte   <= 8'h00;
      rx_shift    <= 8'h00;
      mode_q      <= 1'b0;
      sda_sample  <= 1'b0;
      scl_oe      <= 1'b0;
      sda_oe      <= 1'b0;
      busy        <= 1'b0;
      dataRdy_I2C <= 1'b0;
      ack_err     <= 1'b0;
      readVal_I2C <= 8'h00;
    end else begin
      state       <= state_d;
      qcnt        <= qcnt_d;
      quarter     <= quarter_d;
      bitcnt      <= bitcnt_d;
      scl_oe      <= scl_d;
      sda_oe      <= sda_d;
      busy        <= (state_d != IDLE);
      dataRdy_I2C <= (state_d == DONE);

      if (latch) begin
        addr_byte <= {sensorAddr_I2C, mode_I2C};
        data_byte <= writeVal_I2C;
        mode_q    <= mode_I2C;
        ack_err   <= 1'b0;
        rx_shift  <= 8'h00;
      end

      if (sample_pt) sda_sample <= sda_i;
      if (sample_pt && state == RDATA) rx_shift <= {rx_shift[6:0], sda_i};

      // A released SDA during an acknowledge bit is a NACK; the transaction heads to STOP
      if (bit_end && (state == ACK_A || state == ACK_D) && sda_sample) ack_err <= 1'b1;

      if (state_d == DONE && mode_q && !ack_err) readVal_I2C <= rx_shift;
    end
  end

endmodule

// File: tb/tb_i2c_sensor_master.sv
// Directed scoreboard bench for i2c_sensor_master with a behavioural I2C slave on the bus.
// Two instances (CLK_DIV=4 and CLK_DIV=1) share one slave through a bus select.
module tb_i2c_sensor_master;

  logic       clock = 1'b0;
  logic       rst_n;
  logic [6:0] addr_in;
  logic [7:0] wval_in;
  logic       mode_in;
  logic       start_req;
  logic       sel;

  logic       start0, start1;
  logic [7:0] rval0, rval1;
  logic       rdy0, rdy1, aerr0, aerr1, busy0, busy1;
  logic       scl_oe0, scl_oe1, sda_oe0, sda_oe1;
  logic       scl_bus, sda_bus;
  logic       rdy_m, busy_m, aerr_m;
  logic [7:0] rval_m;

  logic       slave_drv = 1'b0;
  logic       mon_clear, slave_nack;
  logic [7:0] rd_byte, rd_shift;
  logic       prev_scl = 1'b1, prev_sda = 1'b1, s_scl, s_sda;
  logic [7:0] rx_sh, addr_rx, byte2_rx;
  logic       ack1_rx, ack2_rx;
  int         nbits, start_cnt, stop_cnt, run_len, hi_min, hi_max, lo_min, lo_max;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    int         lat;
    logic [7:0] abyte;
    logic [7:0] dbyte;
    logic       ack1;
    logic       ack2;
    logic       aerr;
    logic [7:0] rval;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model_rval [2];

  always #5 clock = ~clock;

  assign start0  = start_req & ~sel;
  assign start1  = start_req & sel;
  assign scl_bus = ~(sel ? scl_oe1 : scl_oe0);
  assign sda_bus = ~((sel ? sda_oe1 : sda_oe0) | slave_drv);
  assign rdy_m   = sel ? rdy1 : rdy0;
  assign busy_m  = sel ? busy1 : busy0;
  assign aerr_m  = sel ? aerr1 : aerr0;
  assign rval_m  = sel ? rval1 : rval0;

  i2c_sensor_master #(.CLK_DIV(4)) dut (
    .clock(clock), .rst_n(rst_n), .sensorAddr_I2C(addr_in), .writeVal_I2C(wval_in),
    .mode_I2C(mode_in), .start_I2C(start0), .readVal_I2C(rval0), .dataRdy_I2C(rdy0),
    .ack_err(aerr0), .busy(busy0), .scl_oe(scl_oe0), .sda_oe(sda_oe0), .sda_i(sda_bus)
  );

  i2c_sensor_master #(.CLK_DIV(1)) dut_fast (
    .clock(clock), .rst_n(rst_n), .sensorAddr_I2C(addr_in), .writeVal_I2C(wval_in),
    .mode_I2C(mode_in), .start_I2C(start1), .readVal_I2C(rval1), .dataRdy_I2C(rdy1),
    .ack_err(aerr1), .busy(busy1), .scl_oe(scl_oe1), .sda_oe(sda_oe1), .sda_i(sda_bus)
  );

  // Slave: decodes START/STOP, captures bits on SCL rise, drives ACK/read data after SCL fall
  always @(negedge clock) begin : slave
    s_scl = scl_bus;
    s_sda = sda_bus;
    if (!rst_n || mon_clear) begin
      nbits = 0; slave_drv = 1'b0; rx_sh = 8'h00; addr_rx = 8'h00; byte2_rx = 8'h00;
      ack1_rx = 1'b0; ack2_rx = 1'b0; start_cnt = 0; stop_cnt = 0; run_len = 0;
      hi_min = 1000; hi_max = 0; lo_min = 1000; lo_max = 0;
    end else begin
      if (s_scl != prev_scl) begin
        if (nbits >= 1 && nbits <= 17) begin
          if (prev_scl) begin
            if (run_len < hi_min) hi_min = run_len;
            if (run_len > hi_max) hi_max = run_len;
          end else begin
            if (run_len < lo_min) lo_min = run_len;
            if (run_len > lo_max) lo_max = run_len;
          end
        end
        run_len = 1;
      end else begin
        run_len++;
      end

      if (prev_scl && s_scl && prev_sda && !s_sda) begin
        start_cnt++; nbits = 0; slave_drv = 1'b0;
      end else if (prev_scl && s_scl && !prev_sda && s_sda) begin
        stop_cnt++; slave_drv = 1'b0;
      end else if (!prev_scl && s_scl) begin
        nbits++;
        rx_sh = {rx_sh[6:0], s_sda};
        if (nbits == 8)  addr_rx  = rx_sh;
        if (nbits == 9)  ack1_rx  = s_sda;
        if (nbits == 17) byte2_rx = rx_sh;
        if (nbits == 18) ack2_rx  = s_sda;
      end else if (prev_scl && !s_scl) begin
        slave_drv = 1'b0;
        if (nbits == 8 && !slave_nack) begin
          slave_drv = 1'b1;
        end else if (!slave_nack && addr_rx[0] && nbits >= 9 && nbits <= 16) begin
          rd_shift  = rd_byte >> (16 - nbits);
          slave_drv = ~rd_shift[0];
        end else if (!addr_rx[0] && nbits == 17) begin
          slave_drv = 1'b1;
        end
      end
    end
    prev_scl = s_scl;
    prev_sda = s_sda;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Expected result of one transaction on the selected instance
  task automatic pushExp(input string tag, input logic [6:0] a, input logic [7:0] d,
                         input logic m, input logic nack, input int gap);
    exp_t e;
    int div = sel ? 1 : 4;
    e.tag   = tag;
    e.abyte = {a, m};
    if (nack) begin
      e.lat = 44 * div + 1 + gap; e.dbyte = 8'h00; e.ack1 = 1'b1; e.ack2 = 1'b0; e.aerr = 1'b1;
    end else begin
      e.lat = 80 * div + 1 + gap; e.dbyte = m ? rd_byte : d; e.ack1 = 1'b0; e.ack2 = m;
      e.aerr = 1'b0;
      if (m) model_rval[sel] = rd_byte;
    end
    e.rval = model_rval[sel];
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input string tag, input logic [6:0] a, input logic [7:0] d,
                               input logic m, input logic nack, input logic hold);
    @(negedge clock);
    mon_clear  = 1'b1;
    slave_nack = nack;
    @(negedge clock);
    @(negedge clock);
    mon_clear = 1'b0;
    addr_in   = a;
    wval_in   = d;
    mode_in   = m;
    start_req = 1'b1;
    pushExp(tag, a, d, m, nack, 0);
    @(negedge clock);
    chk({tag, "_busy"}, busy_m, 1'b1);
    if (hold) begin
      mode_in = 1'b1;
    end else begin
      start_req = 1'b0;
      addr_in   = ~a;
      wval_in   = ~d;
      mode_in   = ~m;
    end
  endtask

  task automatic waitRdy(input int first, output int cyc);
    cyc = first;
    do begin
      @(negedge clock);
      cyc++;
    end while (rdy_m !== 1'b1 && cyc < 2000);
  endtask

  task automatic checkOutput(input int lat);
    exp_t e;
    chk("sb_nonempty", sb.size() != 0, 1'b1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.tag, "_latency"}, lat, e.lat);
      chk({e.tag, "_addr_byte"}, addr_rx, e.abyte);
      chk({e.tag, "_data_byte"}, byte2_rx, e.dbyte);
      chk({e.tag, "_ack_addr"}, ack1_rx, e.ack1);
      chk({e.tag, "_ack_data"}, ack2_rx, e.ack2);
      chk({e.tag, "_ack_err"}, aerr_m, e.aerr);
      chk({e.tag, "_readVal"}, rval_m, e.rval);
      chk({e.tag, "_starts"}, start_cnt, 1);
      chk({e.tag, "_stops"}, stop_cnt, 1);
    end
  endtask

  task automatic checkPulse(input string tag);
    @(negedge clock);
    chk({tag, "_rdy_pulse"}, rdy_m, 1'b0);
    chk({tag, "_idle_busy"}, busy_m, 1'b0);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; sel = 1'b0; start_req = 1'b0; addr_in = 7'h00; wval_in = 8'h00;
    mode_in = 1'b0; mon_clear = 1'b0; slave_nack = 1'b0; rd_byte = 8'h00;
    model_rval[0] = 8'h00; model_rval[1] = 8'h00;

    repeat (3) @(negedge clock);
    chk("rst_scl_oe", scl_oe0, 1'b0);
    chk("rst_sda_oe", sda_oe0, 1'b0);
    chk("rst_dataRdy", rdy0, 1'b0);
    chk("rst_readVal", rval0, 8'h00);
    chk("rst_ack_err", aerr0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_fast_scl_oe", scl_oe1, 1'b0);
    rst_n = 1'b1;
    @(negedge clock);

    applyStimulus("wr", 7'h48, 8'hA5, 1'b0, 1'b0, 1'b0);
    waitRdy(1, lat);
    checkOutput(lat);
    checkPulse("wr");

    rd_byte = 8'h3C;
    applyStimulus("rd", 7'h48, 8'h00, 1'b1, 1'b0, 1'b0);
    waitRdy(1, lat);
    checkOutput(lat);
    checkPulse("rd");
    repeat (20) @(negedge clock);
    chk("rd_hold", rval0, 8'h3C);

    applyStimulus("nack", 7'h48, 8'h00, 1'b1, 1'b1, 1'b0);
    waitRdy(1, lat);
    checkOutput(lat);
    checkPulse("nack");
    repeat (5) @(negedge clock);
    chk("nack_err_hold", aerr0, 1'b1);

    // Write with start held high; mode flips to read mid-transaction
    rd_byte = 8'hC3;
    applyStimulus("b2b_wr", 7'h48, 8'h5A, 1'b0, 1'b0, 1'b1);
    pushExp("b2b_rd", 7'h48, 8'h5A, 1'b1, 1'b0, 1);
    waitRdy(1, lat);
    checkOutput(lat);
    mon_clear = 1'b1;
    @(negedge clock);
    chk("b2b_gap_rdy", rdy0, 1'b0);
    chk("b2b_gap_busy", busy0, 1'b0);
    @(negedge clock);
    mon_clear = 1'b0;
    start_req = 1'b0;
    chk("b2b_relatch", busy0, 1'b1);
    waitRdy(2, lat);
    checkOutput(lat);
    checkPulse("b2b_rd");

    // Reset in the middle of address bit 1 (SCL and SDA both pulled low there)
    @(negedge clock);
    addr_in = 7'h48; wval_in = 8'h11; mode_in = 1'b0; start_req = 1'b1;
    @(negedge clock);
    start_req = 1'b0;
    repeat (34) @(negedge clock);
    chk("pre_rst_scl_oe", scl_oe0, 1'b1);
    chk("pre_rst_sda_oe", sda_oe0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_scl_oe", scl_oe0, 1'b0);
    chk("mid_rst_sda_oe", sda_oe0, 1'b0);
    chk("mid_rst_busy", busy0, 1'b0);
    chk("mid_rst_dataRdy", rdy0, 1'b0);
    chk("mid_rst_ack_err", aerr0, 1'b0);
    chk("mid_rst_readVal", rval0, 8'h00);
    model_rval[0] = 8'h00;
    @(negedge clock);
    rst_n = 1'b1;

    applyStimulus("post_rst", 7'h21, 8'h7E, 1'b0, 1'b0, 1'b0);
    waitRdy(1, lat);
    checkOutput(lat);
    checkPulse("post_rst");

    sel = 1'b1;
    applyStimulus("fast", 7'h48, 8'hA5, 1'b0, 1'b0, 1'b0);
    waitRdy(1, lat);
    checkOutput(lat);
    chk("fast_scl_hi_min", hi_min, 2);
    chk("fast_scl_hi_max", hi_max, 2);
    chk("fast_scl_lo_min", lo_min, 2);
    chk("fast_scl_lo_max", lo_max, 2);
    checkPulse("fast");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
